// File: rtl/bwt_last_column_out_if.sv
// Output byte stream of the BWT last-column stage: valid/ready handshake
// carrying one BWT byte per transfer plus an end-of-block marker.
interface bwt_last_column_out_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bwt_last_column_out.sv
// BWT last-column output stage. Captures the last byte of each sorted
// rotation row into a small buffer, records the first row equal to the
// unrotated string as the primary index, then streams the buffered bytes
// out over a valid/ready handshake and pulses done with the index.
module bwt_last_column_out #(
    parameter int COLUMN     = 3,
    parameter int STRING_LEN = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*COLUMN-1:0]   orig_row,
    input  logic                  row_valid,
    input  logic [8*COLUMN-1:0]   row_data,
    bwt_last_column_out_if.master out_if,
    output logic [IDX_W-1:0]      prim_idx,
    output logic                  prim_found,
    output logic                  done,
    output logic                  overrun
);

    localparam int                 CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STRING_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        wr_cnt_q;
    logic [CNT_W-1:0]        rd_cnt_q;
    logic                    match_q;
    logic [STRING_LEN-1:0]   bvld_q;
    logic [8*COLUMN-1:0]     orig_q;
    logic [7:0]              buf_q [STRING_LEN];
    logic                    out_valid_q;
    logic [7:0]              out_data_q;
    logic                    out_last_q;
    logic [IDX_W-1:0]        prim_idx_q;
    logic                    prim_found_q;
    logic                    done_q;
    logic                    overrun_q;

    logic [CNT_W-1:0]        wr_cnt_d;
    logic [CNT_W-1:0]        rd_cnt_d;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_nxt_idx;
    logic [7:0]              rd_nxt_byte_d;
    logic [7:0]              first_byte_d;
    logic                    start_acc;
    logic                    row_we;
    logic                    row_hit;

    // Counter increments, buffer read ports and write/arm qualifiers.
    always_comb begin
        wr_cnt_d      = wr_cnt_q + CNT_W'(1);
        rd_cnt_d      = rd_cnt_q + CNT_W'(1);
        wr_idx        = wr_cnt_q[IDX_W-1:0];
        rd_nxt_idx    = rd_cnt_d[IDX_W-1:0];
        rd_nxt_byte_d = bvld_q[rd_nxt_idx] ? buf_q[rd_nxt_idx] : 8'h00;
        first_byte_d  = bvld_q[0] ? buf_q[0] : 8'h00;
        // A start is only honoured while no output is in flight.
        start_acc     = start && ((state_q == S_IDLE) || (state_q == S_COLLECT));
        // A start in the same cycle as a row restarts the block; the row is dropped.
        row_we        = (state_q == S_COLLECT) && row_valid && !start;
        row_hit       = (row_data == orig_q);
    end

    // Data storage: latched original string and last-column byte buffer.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            orig_q <= orig_row;
        end
        if (row_we) begin
            buf_q[wr_idx] <= row_data[8*COLUMN-1 -: 8];
        end
    end

    // Block sequencer with all handshake and status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            match_q      <= 1'b0;
            bvld_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            prim_idx_q   <= '1;
            prim_found_q <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                state_q      <= S_COLLECT;
                wr_cnt_q     <= '0;
                rd_cnt_q     <= '0;
                match_q      <= 1'b0;
                bvld_q       <= '0;
                prim_idx_q   <= '1;
                prim_found_q <= 1'b0;
                overrun_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_COLLECT: begin
                        if (row_we) begin
                            bvld_q[wr_idx] <= 1'b1;
                            wr_cnt_q       <= wr_cnt_d;
                            // First match wins so periodic strings report the lowest row.
                            if (row_hit && !match_q) begin
                                prim_idx_q <= wr_idx;
                                match_q    <= 1'b1;
                            end
                            if (wr_cnt_q == CNT_LAST) begin
                                state_q     <= S_EMIT;
                                out_valid_q <= 1'b1;
                                out_data_q  <= first_byte_d;
                                out_last_q  <= 1'b0;
                            end
                        end
                    end
                    S_EMIT: begin
                        // Rows arriving now have nowhere to go; flag and drop them.
                        if (row_valid) begin
                            overrun_q <= 1'b1;
                        end
                        if (out_valid_q && out_if.out_ready) begin
                            rd_cnt_q <= rd_cnt_d;
                            if (out_last_q) begin
                                state_q      <= S_DONE;
                                out_valid_q  <= 1'b0;
                                out_last_q   <= 1'b0;
                                done_q       <= 1'b1;
                                prim_found_q <= match_q;
                            end else begin
                                out_data_q <= rd_nxt_byte_d;
                                out_last_q <= (rd_cnt_d == CNT_LAST);
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;
    assign prim_idx         = prim_idx_q;
    assign prim_found       = prim_found_q;
    assign done             = done_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_bwt_last_column_out.sv
// Randomised bench for bwt_last_column_out with an in-bench block model
// and a per-cycle output monitor.
module tb_bwt_last_column_out;

    localparam int COLUMN     = 3;
    localparam int STRING_LEN = 8;
    localparam int IDX_W      = 3;
    localparam int RW         = 8 * COLUMN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [RW-1:0]     orig_row = '0;
    logic              row_valid = 1'b0;
    logic [RW-1:0]     row_data = '0;
    logic [IDX_W-1:0]  prim_idx;
    logic              prim_found;
    logic              done;
    logic              overrun;

    bwt_last_column_out_if out_if();

    bwt_last_column_out #(
        .COLUMN(COLUMN), .STRING_LEN(STRING_LEN), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .orig_row(orig_row),
        .row_valid(row_valid), .row_data(row_data), .out_if(out_if),
        .prim_idx(prim_idx), .prim_found(prim_found), .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0]  blk [STRING_LEN];
    logic [7:0]     exp_q [$];
    bit             last_q [$];
    int             exp_idx = STRING_LEN - 1;
    bit             exp_found = 1'b0;
    int             hold_idx = STRING_LEN - 1;
    bit             hold_found = 1'b0;
    int             rdy_mode = 0;
    int             rdy_phase = 0;

    bit             prev_last = 1'b0;
    bit             held = 1'b0;
    logic [7:0]     hd;
    logic           hl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mkrow(input string s);
        return {s[2], s[1], s[0]};
    endfunction

    // Block model: BWT bytes are the last byte of each row in arrival order;
    // primary index is the first row equal to the original string.
    task automatic model(input logic [RW-1:0] orig, output logic [8*STRING_LEN-1:0] bytes_o,
                         output int idx, output bit found);
        bytes_o = '0;
        idx     = STRING_LEN - 1;
        found   = 1'b0;
        for (int i = 0; i < STRING_LEN; i++) begin
            bytes_o[8*(STRING_LEN-1-i) +: 8] = blk[i][RW-1 -: 8];
            if (!found && blk[i] == orig) begin
                idx   = i;
                found = 1'b1;
            end
        end
    endtask

    task automatic build_expect(input logic [RW-1:0] orig);
        logic [8*STRING_LEN-1:0] b;
        int  ix;
        bit  f;
        model(orig, b, ix, f);
        for (int i = 0; i < STRING_LEN; i++) begin
            exp_q.push_back(b[8*(STRING_LEN-1-i) +: 8]);
            last_q.push_back(i == STRING_LEN - 1);
        end
        exp_idx   = ix;
        exp_found = f;
    endtask

    task automatic run_block(input logic [RW-1:0] orig, input int gap, input bit inject,
                             input bit restart);
        int n;
        chk("prim_idx_hold", prim_idx, hold_idx);
        chk("prim_found_hold", prim_found, hold_found);
        start = 1'b1; orig_row = orig;
        tick();
        start = 1'b0;
        chk("overrun_clear", overrun, 0);
        if (restart) begin
            for (int i = 0; i < 3; i++) begin
                row_valid = 1'b1; row_data = RW'($urandom);
                tick();
            end
            row_valid = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < STRING_LEN; i++) begin
            if (gap > 0) begin
                row_valid = 1'b0;
                repeat ($urandom_range(0, gap)) tick();
            end
            row_valid = 1'b1; row_data = blk[i];
            if (i == STRING_LEN - 1) build_expect(orig);
            tick();
        end
        row_valid = 1'b0;
        chk("first_valid_latency", out_if.out_valid, 1);
        if (inject) begin
            tick();
            row_valid = 1'b1; row_data = RW'($urandom);
            tick();
            row_valid = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout actual=%0d cycles required=done", n);
        end
        chk("overrun_at_done", overrun, inject);
        hold_idx   = exp_idx;
        hold_found = exp_found;
        tick();
    endtask

    // Consumer ready generator: always, 1-0-0 pattern, or random.
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_if.out_ready = (rdy_phase == 0);
                    rdy_phase = (rdy_phase + 1) % 3;
                end
                2: out_if.out_ready = 1'($urandom_range(0, 1));
                default: out_if.out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard, hold-stability and done timing every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_last = 1'b0;
                held = 1'b0;
            end else begin
                chk("done_pulse", done, prev_last);
                prev_last = 1'b0;
                if (done) begin
                    chk("prim_idx", prim_idx, exp_idx);
                    chk("prim_found", prim_found, exp_found);
                end
                if (out_if.out_valid) begin
                    if (held) begin
                        chk("hold_data", out_if.out_data, hd);
                        chk("hold_last", out_if.out_last, hl);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid actual=%0h required=no_valid", out_if.out_data);
                        held = 1'b0;
                    end else if (out_if.out_ready) begin
                        chk("out_data", out_if.out_data, exp_q.pop_front());
                        chk("out_last", out_if.out_last, last_q.pop_front());
                        prev_last = out_if.out_last;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        hd = out_if.out_data;
                        hl = out_if.out_last;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [8*STRING_LEN-1:0] mb;
        int  mi;
        bit  mf;
        logic [RW-1:0] o;
        logic [63:0] lit;

        repeat (2) tick();
        chk("rst_out_valid", out_if.out_valid, 0);
        chk("rst_out_data", out_if.out_data, 0);
        chk("rst_out_last", out_if.out_last, 0);
        chk("rst_prim_idx", prim_idx, 7);
        chk("rst_prim_found", prim_found, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        // Rows while idle must be ignored and not flag overrun.
        row_valid = 1'b1; row_data = RW'($urandom);
        tick();
        row_valid = 1'b0;
        chk("idle_row_no_overrun", overrun, 0);

        // Basic case: orig "abc", row 2 equals it, last column "abcabcab".
        o = mkrow("abc");
        blk[0] = mkrow("bca"); blk[1] = mkrow("cab"); blk[2] = mkrow("abc");
        blk[3] = mkrow("bca"); blk[4] = mkrow("cab"); blk[5] = mkrow("aac");
        blk[6] = mkrow("bba"); blk[7] = mkrow("ccb");
        model(o, mb, mi, mf);
        lit = "abcabcab";
        chk("model_basic_bytes", mb, lit);
        chk("model_basic_idx", mi, 2);
        chk("model_basic_found", mf, 1);
        rdy_mode = 0;
        run_block(o, 0, 0, 0);
        chk("basic_prim_idx", prim_idx, 2);
        chk("basic_prim_found", prim_found, 1);

        // Same block under 1,0,0 backpressure, then gapped rows.
        rdy_mode = 1;
        run_block(o, 0, 0, 0);
        rdy_mode = 0;
        run_block(o, 3, 0, 0);

        // Random rows, no match, random ready.
        o = RW'($urandom);
        for (int i = 0; i < STRING_LEN; i++) begin
            blk[i] = RW'($urandom);
            if (blk[i] == o) blk[i] = ~o;
        end
        model(o, mb, mi, mf);
        chk("model_nomatch_idx", mi, 7);
        chk("model_nomatch_found", mf, 0);
        rdy_mode = 2;
        run_block(o, 2, 0, 0);

        // Repeated match at rows 3 and 5; first wins.
        for (int i = 0; i < STRING_LEN; i++) begin
            blk[i] = RW'($urandom);
            if (blk[i] == o) blk[i] = ~o;
        end
        blk[3] = o; blk[5] = o;
        model(o, mb, mi, mf);
        chk("model_repeat_idx", mi, 3);
        run_block(o, 1, 0, 1);

        // Overrun: row pulsed during output; stream unchanged.
        for (int i = 0; i < STRING_LEN; i++) blk[i] = RW'($urandom);
        blk[6] = o;
        rdy_mode = 0;
        run_block(o, 0, 1, 0);
        rdy_mode = 2;
        run_block(o, 1, 0, 0);

        // Reset mid-block after 4 rows.
        start = 1'b1; orig_row = o;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row_valid = 1'b1; row_data = blk[i];
            tick();
        end
        row_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_if.out_valid, 0);
        chk("mid_rst_out_data", out_if.out_data, 0);
        chk("mid_rst_out_last", out_if.out_last, 0);
        chk("mid_rst_prim_idx", prim_idx, 7);
        chk("mid_rst_prim_found", prim_found, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_overrun", overrun, 0);
        tick();
        rst = 1'b1;
        hold_idx = STRING_LEN - 1;
        hold_found = 1'b0;
        for (int i = 0; i < STRING_LEN; i++) blk[i] = RW'($urandom);
        blk[1] = o;
        rdy_mode = 1;
        run_block(o, 0, 0, 0);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL undelivered_bytes actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
